// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter that owns the select of a shared 8:1 mux.
// Grants are held until the owner drops its request or the hold limit expires.
module mux_rr_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [7:0]        i_req,
    output logic [2:0]        o_sel,
    output logic [7:0]        o_gnt,
    output logic              o_valid,
    output logic [HOLD_W-1:0] o_hold_cnt
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            r_state;
    logic [2:0]        r_ptr;
    logic [2:0]        r_sel;
    logic [7:0]        r_gnt;
    logic              r_valid;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [2:0]        w_idx;
    logic [2:0]        w_pick;
    logic              w_found;
    logic              w_at_limit;
    logic              w_release;

    // First set request at or after the round-robin pointer, wrapping mod 8.
    always_comb begin
        w_idx   = r_ptr;
        w_pick  = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && i_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_at_limit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD));
        w_release  = !i_req[r_sel] || w_at_limit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_ptr      <= 3'd0;
            r_sel      <= 3'd0;
            r_gnt      <= 8'd0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_en && w_found) begin
                        r_state    <= StGrant;
                        r_sel      <= w_pick;
                        r_gnt      <= 8'd1 << w_pick;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= HOLD_W'(1);
                    end
                end
                StGrant: begin
                    if (w_release) begin
                        r_state    <= StIdle;
                        r_gnt      <= 8'd0;
                        r_valid    <= 1'b0;
                        r_hold_cnt <= '0;
                        r_ptr      <= r_sel + 3'd1;
                    end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                        // Saturates rather than wraps when there is no hold limit.
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_sel      = r_sel;
    assign o_gnt      = r_gnt;
    assign o_valid    = r_valid;
    assign o_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Directed bench for mux_rr_sel_arbiter: MAX_HOLD=4 main instance plus an
// unlimited-hold instance with a narrow counter to exercise saturation.
module tb_mux_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [2:0] sel_a;
    logic [7:0] gnt_a;
    logic       valid_a;
    logic [7:0] hold_a;

    logic [2:0] sel_b;
    logic [7:0] gnt_b;
    logic       valid_b;
    logic [1:0] hold_b;

    int checks = 0;
    int errors = 0;

    mux_rr_sel_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_req      (req),
        .o_sel      (sel_a),
        .o_gnt      (gnt_a),
        .o_valid    (valid_a),
        .o_hold_cnt (hold_a)
    );

    mux_rr_sel_arbiter #(.MAX_HOLD(0), .HOLD_W(2)) u_dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_req      (req),
        .o_sel      (sel_b),
        .o_gnt      (gnt_b),
        .o_valid    (valid_b),
        .o_hold_cnt (hold_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_valid_eq_or_gnt", 32'(valid_a), 32'(|gnt_a));
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] s, input logic [7:0] h);
        chk({tag, "_valid"}, 32'(valid_a), 32'd1);
        chk({tag, "_sel"},   32'(sel_a),   32'(s));
        chk({tag, "_gnt"},   32'(gnt_a),   32'(8'd1 << s));
        chk({tag, "_hold"},  32'(hold_a),  32'(h));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_gnt"},   32'(gnt_a),   32'd0);
        chk({tag, "_hold"},  32'(hold_a),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;

        // Reset held with all requests asserted
        tick();
        tick();
        chk_idle("reset");
        chk("reset_sel", 32'(sel_a), 32'd0);
        rst_n = 1'b1;
        req   = 8'h00;
        tick();
        chk_idle("post_reset_noreq");

        // Single requester on channel 2 for three sampled edges
        req = 8'h04;
        tick(); chk_grant("single_c1", 3'd2, 8'd1);
        tick(); chk_grant("single_c2", 3'd2, 8'd2);
        tick(); chk_grant("single_c3", 3'd2, 8'd3);
        req = 8'h00;
        tick(); chk_idle("single_rel");
        chk("single_sel_held", 32'(sel_a), 32'd2);

        // Skip pattern from ptr=3: 7 first, then wrap to 1
        req = 8'b1000_0010;
        tick(); chk_grant("skip_first", 3'd7, 8'd1);
        req = 8'b0000_0010;
        tick(); chk_idle("skip_rel");
        tick(); chk_grant("skip_wrap", 3'd1, 8'd1);
        req = 8'h00;
        tick(); chk_idle("skip_rel2");

        // Async reset mid-grant (ptr=2 here, so channel 2 is granted)
        req = 8'hFF;
        tick(); chk_grant("pre_rst", 3'd2, 8'd1);
        tick(); chk_grant("pre_rst2", 3'd2, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_sel", 32'(sel_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full contention: 4-cycle grants, one idle bubble, ptr wraps 7 -> 0
        for (int ch = 0; ch < 8; ch++) begin
            for (int h = 1; h <= 4; h++) begin
                tick();
                chk_grant($sformatf("rr_ch%0d_h%0d", ch, h), 3'(ch), 8'(h));
            end
            tick();
            chk_idle($sformatf("rr_bubble%0d", ch));
        end
        tick(); chk_grant("rr_wrap", 3'd0, 8'd1);

        // Request drops on the same cycle the hold limit is reached
        tick(); chk_grant("sim_h2", 3'd0, 8'd2);
        tick(); chk_grant("sim_h3", 3'd0, 8'd3);
        tick(); chk_grant("sim_h4", 3'd0, 8'd4);
        req = 8'hFE;
        tick(); chk_idle("sim_rel");
        tick(); chk_grant("sim_next", 3'd1, 8'd1);
        req = 8'h00;
        tick(); chk_idle("sim_rel2");

        // Enable gating
        en  = 1'b0;
        req = 8'h10;
        tick(); chk_idle("en0_a");
        tick(); chk_idle("en0_b");
        en = 1'b1;
        tick(); chk_grant("en1", 3'd4, 8'd1);
        en = 1'b0;
        tick(); chk_grant("en_drop_h2", 3'd4, 8'd2);
        tick(); chk_grant("en_drop_h3", 3'd4, 8'd3);
        req = 8'h00;
        tick(); chk_idle("en_drop_rel");
        req = 8'h10;
        tick(); chk_idle("en0_after");

        // No hold limit: grant persists and counter saturates at 3 (2-bit)
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        en  = 1'b1;
        req = 8'h01;
        for (int h = 1; h <= 6; h++) begin
            tick();
            chk($sformatf("sat_valid%0d", h), 32'(valid_b), 32'd1);
            chk($sformatf("sat_sel%0d", h),   32'(sel_b),   32'd0);
            chk($sformatf("sat_hold%0d", h),  32'(hold_b),  32'((h > 3) ? 3 : h));
        end
        req = 8'h00;
        tick();
        chk("sat_rel_valid", 32'(valid_b), 32'd0);
        chk("sat_rel_hold",  32'(hold_b),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
